// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command codes, FSM states and frame sizing.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Default payload width and the serial frame built from it (command + payload).
  localparam int ADDR_SIZE_DEF = 8;
  localparam int FRAME_W       = ADDR_SIZE_DEF + 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEL,
    SHIFT,
    WAIT,
    CAPTURE,
    END
  } state_t;

  // Frame width for an arbitrary payload width.
  function automatic int frame_width(input int addr_size);
    return addr_size + 2;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Load / shift-left register with serial in and out, plus a down-counter whose
// done flag tells the controller how many shifts remain.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int W  = FRAME_W,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          shift,
  input  logic          sin,
  input  logic [W-1:0]  load_data,
  input  logic [CW-1:0] load_cnt,
  output logic [W-1:0]  q,
  output logic          sout,
  output logic          done
);

  logic [CW-1:0] cnt;

  // Parallel load wins over shift; the counter stops at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, matching the hardware it describes.
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_data;
      cnt <= load_cnt;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  assign sout = q[W-1];
  assign done = (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: turns a {cmd, payload} request into the slave's serial frame and,
// for read-data commands, captures the returned byte from miso.
// RD_GAP and END_GAP are expected to be at least 1.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int RD_GAP    = 2,
  parameter int END_GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [ADDR_SIZE-1:0] req_data,
  output logic                 busy,
  output logic [ADDR_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 ss_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int FW = frame_width(ADDR_SIZE);
  localparam int CW = $clog2(ADDR_SIZE + 3);

  state_t                 state;
  logic [1:0]             cmd;
  logic [CW-1:0]          gap_cnt;
  logic                   accept;

  logic                   tx_load, tx_shift, tx_sout, tx_done;
  logic [FW-1:0]          tx_q;
  logic                   rx_load, rx_shift, rx_sout, rx_done;
  logic [ADDR_SIZE-1:0]   rx_q;
  logic                   unused_bits;

  assign accept   = req_valid && req_ready;

  // The tx register is loaded at acceptance and shifts once per transmitted bit,
  // starting on the SEL->SHIFT edge so mosi always shows the pre-shift MSB.
  assign tx_load  = accept;
  assign tx_shift = (state == SEL) || ((state == SHIFT) && !tx_done);

  // The rx register is primed on the last WAIT edge and shifts miso in during CAPTURE.
  assign rx_load  = (state == WAIT) && (gap_cnt == '0);
  assign rx_shift = (state == CAPTURE);

  // Parallel tx bits and the rx serial output are not needed by this controller.
  assign unused_bits = ^{tx_q, rx_sout};

  // tx counter starts at FW: done rises once every frame bit has been shifted out.
  spi_shift_reg #(.W(FW), .CW(CW)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .shift     (tx_shift),
    .sin       (1'b0),
    .load_data ({req_cmd, req_data}),
    .load_cnt  (CW'(FW)),
    .q         (tx_q),
    .sout      (tx_sout),
    .done      (tx_done)
  );

  // rx counter starts one short: done marks the edge that samples the final bit,
  // which is merged straight into rd_data on that same edge.
  spi_shift_reg #(.W(ADDR_SIZE), .CW(CW)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rx_load),
    .shift     (rx_shift),
    .sin       (miso),
    .load_data ('0),
    .load_cnt  (CW'(ADDR_SIZE - 1)),
    .q         (rx_q),
    .sout      (rx_sout),
    .done      (rx_done)
  );

  // Frame sequencer with registered pin and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd       <= '0;
      gap_cnt   <= '0;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      // NOTE: rd_valid defaults low every cycle so the single set below is a one-cycle pulse.
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= START;
            cmd       <= req_cmd;
            ss_n      <= 1'b0;
            mosi      <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          state <= SEL;
          mosi  <= cmd[1];
        end
        SEL: begin
          state <= SHIFT;
          mosi  <= tx_sout;
        end
        SHIFT: begin
          if (tx_done) begin
            mosi <= 1'b0;
            if (cmd == CMD_RD_DATA) begin
              state   <= WAIT;
              gap_cnt <= CW'(RD_GAP - 1);
            end else begin
              state   <= END;
              ss_n    <= 1'b1;
              gap_cnt <= CW'(END_GAP - 1);
            end
          end else begin
            mosi <= tx_sout;
          end
        end
        WAIT: begin
          if (gap_cnt == '0) state <= CAPTURE;
          else               gap_cnt <= gap_cnt - CW'(1);
        end
        CAPTURE: begin
          if (rx_done) begin
            rd_data  <= {rx_q[ADDR_SIZE-2:0], miso};
            rd_valid <= 1'b1;
            state    <= END;
            ss_n     <= 1'b1;
            gap_cnt  <= CW'(END_GAP - 1);
          end
        end
        END: begin
          if (gap_cnt == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (RD_GAP=2 and RD_GAP=3) driven by
// directed and random command sequences against a frame-level slave model.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] miso;
  logic [1:0] req_cmd  [2];
  logic [7:0] req_data [2];

  logic       req_ready_0, busy_0, rd_valid_0, ss_n_0, mosi_0;
  logic       req_ready_1, busy_1, rd_valid_1, ss_n_1, mosi_1;
  logic [7:0] rd_data_0, rd_data_1;

  logic [1:0] req_ready_v, busy_v, rd_valid_v, ss_n_v, mosi_v;
  logic [7:0] rd_data_v [2];

  assign req_ready_v  = {req_ready_1, req_ready_0};
  assign busy_v       = {busy_1, busy_0};
  assign rd_valid_v   = {rd_valid_1, rd_valid_0};
  assign ss_n_v       = {ss_n_1, ss_n_0};
  assign mosi_v       = {mosi_1, mosi_0};
  assign rd_data_v[0] = rd_data_0;
  assign rd_data_v[1] = rd_data_1;

  int tests = 0;
  int fails = 0;
  int cur   = 0;

  // Slave model per instance: address register, RAM, and the last byte read back.
  logic [7:0] ram     [2][256];
  logic [7:0] addr_q  [2];
  logic [7:0] last_rd [2];

  always #5 clk = ~clk;

  spi_master_ctrl #(.ADDR_SIZE(8), .RD_GAP(2), .END_GAP(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready_0),
    .req_cmd(req_cmd[0]), .req_data(req_data[0]),
    .busy(busy_0), .rd_data(rd_data_0), .rd_valid(rd_valid_0),
    .ss_n(ss_n_0), .mosi(mosi_0), .miso(miso[0])
  );

  spi_master_ctrl #(.ADDR_SIZE(8), .RD_GAP(3), .END_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready_1),
    .req_cmd(req_cmd[1]), .req_data(req_data[1]),
    .busy(busy_1), .rd_data(rd_data_1), .rd_valid(rd_valid_1),
    .ss_n(ss_n_1), .mosi(mosi_1), .miso(miso[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, cur, obs, exp);
    end
  endtask

  // Issue one command to instance u and follow its whole frame until IDLE.
  // With hold set, req_valid stays high and the next command is presented
  // right after acceptance.
  task automatic do_cmd(input int u, input logic [1:0] c, input logic [7:0] d,
                        input bit hold, input logic [1:0] nc, input logic [7:0] nd);
    int         gap, exp_len, low, rdy_lo, bsy, rv, rv_at, wait_cyc, j, n;
    logic [11:0] got, exp_bits;
    logic [7:0]  rbyte, rv_data;
    cur      = u;
    gap      = (u == 0) ? 2 : 3;
    exp_len  = (c == CMD_RD_DATA) ? 12 + gap + 8 : 12;
    rbyte    = ram[u][addr_q[u]];
    exp_bits = {1'b0, c[1], c, d};

    wait_cyc = 0;
    while (!req_ready_v[u] && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("ready_before_cmd", 32'(req_ready_v[u]), 1);

    req_valid[u] = 1'b1;
    req_cmd[u]   = c;
    req_data[u]  = d;
    @(negedge clk);  // acceptance edge has passed
    if (hold) begin
      req_cmd[u]  = nc;
      req_data[u] = nd;
    end else begin
      req_valid[u] = 1'b0;
      req_data[u]  = 8'($urandom);
    end

    low = 0; rdy_lo = 0; bsy = 0; rv = 0; rv_at = -1; n = 0;
    got = '0; rv_data = '0;
    for (int k = 0; k < exp_len + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (!ss_n_v[u]) begin
        low++;
        if (n < 12) begin
          got = {got[10:0], mosi_v[u]};
          n++;
        end
      end
      if (!req_ready_v[u]) rdy_lo++;
      if (busy_v[u]) bsy++;
      if (rd_valid_v[u]) begin
        rv++;
        rv_at   = k;
        rv_data = rd_data_v[u];
      end
      // miso bit for the edge k+1; first capture edge is 13+gap
      j = k + 1 - (13 + gap);
      miso[u] = (j >= 0 && j < 8) ? rbyte[7-j] : 1'($urandom_range(0, 1));
    end

    check("ss_low_cycles", low, exp_len);
    check("mosi_bits", got, exp_bits);
    check("ready_low_cycles", rdy_lo, exp_len + 1);
    check("busy_cycles", bsy, exp_len + 1);
    check("ready_back", 32'(req_ready_v[u]), 1);
    check("rd_valid_count", rv, (c == CMD_RD_DATA) ? 1 : 0);
    if (c == CMD_RD_DATA) begin
      check("rd_valid_cycle", rv_at, exp_len);
      check("rd_data_pulse", rv_data, rbyte);
    end

    case (c)
      CMD_WR_ADDR: addr_q[u] = d;
      CMD_WR_DATA: ram[u][addr_q[u]] = d;
      CMD_RD_ADDR: addr_q[u] = d;
      default:     last_rd[u] = rbyte;
    endcase
    check("rd_data_hold", rd_data_v[u], last_rd[u]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;
    logic [7:0] a_list [4];
    int rv_seen;

    rst_n     = 1'b1;
    req_valid = '0;
    miso      = '0;
    for (int u = 0; u < 2; u++) begin
      req_cmd[u]  = '0;
      req_data[u] = '0;
      addr_q[u]   = '0;
      last_rd[u]  = '0;
      for (int i = 0; i < 256; i++) ram[u][i] = '0;
    end

    // Reset values
    #2 rst_n = 1'b0;
    #6;
    for (int u = 0; u < 2; u++) begin
      cur = u;
      check("rst_ss_n", 32'(ss_n_v[u]), 1);
      check("rst_mosi", 32'(mosi_v[u]), 0);
      check("rst_ready", 32'(req_ready_v[u]), 1);
      check("rst_busy", 32'(busy_v[u]), 0);
      check("rst_rd_valid", 32'(rd_valid_v[u]), 0);
      check("rst_rd_data", rd_data_v[u], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: write 0xC3 to 0x5A, then read it back
    do_cmd(0, CMD_WR_ADDR, 8'h5A, 0, 2'b00, 8'h00);
    do_cmd(0, CMD_WR_DATA, 8'hC3, 0, 2'b00, 8'h00);
    do_cmd(0, CMD_RD_ADDR, 8'h5A, 0, 2'b00, 8'h00);
    do_cmd(0, CMD_RD_DATA, 8'($urandom), 0, 2'b00, 8'h00);
    cur = 0;
    check("directed_rd_c3", rd_data_v[0], 8'hC3);

    // Reset in the middle of a wr_addr SHIFT phase
    cur = 0;
    req_valid[0] = 1'b1;
    req_cmd[0]   = CMD_WR_ADDR;
    req_data[0]  = 8'h33;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("mid_ss_low_before", 32'(ss_n_v[0]), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss_n", 32'(ss_n_v[0]), 1);
    check("mid_rst_mosi", 32'(mosi_v[0]), 0);
    check("mid_rst_ready", 32'(req_ready_v[0]), 1);
    check("mid_rst_busy", 32'(busy_v[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_valid_v != 2'b00) rv_seen++;
    end
    check("mid_no_rd_valid", rv_seen, 0);
    check("mid_ready_after", 32'(req_ready_v[0]), 1);
    check("mid_ss_n_after", 32'(ss_n_v[0]), 1);
    check("mid_rd_data_clr", rd_data_v[0], 0);
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Random writes then read-backs
    for (int i = 0; i < 4; i++) begin
      a_list[i] = 8'($urandom);
      d = 8'($urandom);
      do_cmd(0, CMD_WR_ADDR, a_list[i], 0, 2'b00, 8'h00);
      do_cmd(0, CMD_WR_DATA, d, 0, 2'b00, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, CMD_RD_ADDR, a_list[i], 0, 2'b00, 8'h00);
      do_cmd(0, CMD_RD_DATA, 8'($urandom), 0, 2'b00, 8'h00);
    end
    for (int i = 0; i < 6; i++)
      do_cmd(0, 2'($urandom_range(0, 3)), 8'($urandom), 0, 2'b00, 8'h00);

    // req_valid held high across four back-to-back commands
    a = 8'($urandom);
    d = 8'($urandom);
    do_cmd(0, CMD_WR_ADDR, a, 1, CMD_WR_DATA, d);
    do_cmd(0, CMD_WR_DATA, d, 1, CMD_RD_ADDR, a);
    do_cmd(0, CMD_RD_ADDR, a, 1, CMD_RD_DATA, 8'hFF);
    do_cmd(0, CMD_RD_DATA, 8'hFF, 0, 2'b00, 8'h00);
    cur = 0;
    check("hold_rd_back", rd_data_v[0], d);

    // RD_GAP=3 instance
    for (int i = 0; i < 2; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      do_cmd(1, CMD_WR_ADDR, a, 0, 2'b00, 8'h00);
      do_cmd(1, CMD_WR_DATA, d, 0, 2'b00, 8'h00);
      do_cmd(1, CMD_RD_ADDR, a, 0, 2'b00, 8'h00);
      do_cmd(1, CMD_RD_DATA, 8'($urandom), 0, 2'b00, 8'h00);
      cur = 1;
      check("gap3_rd_back", rd_data_v[1], d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
